// File: rtl/vchanel_fifo_bank.sv
// Four virtual-channel FWFT FIFOs fed by a class-tagged write port and drained by one-hot pops.
// Latency: a word written at edge k is on out_vchanelN right after edge k; a pop advances the head at that edge.
// Backpressure: almost_full/full per channel; a push to a full channel without a same-cycle pop is dropped and flagged.

module vc_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_vld,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop_vld,
    output logic [DATA_W-1:0] head_dat,
    output logic [PTR_W:0]    count,
    output logic              push_drop,
    output logic              pop_udf
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              is_empty;
    logic              is_full;
    logic              push_ok;
    logic              pop_ok;

    assign is_empty  = (count == '0);
    assign is_full   = (count == FULL_CNT);
    assign pop_ok    = pop_vld && !is_empty;
    // A full FIFO can still take a word when its head leaves in the same cycle.
    assign push_ok   = push_vld && (!is_full || pop_vld);
    assign push_drop = push_vld && !push_ok;
    assign pop_udf   = pop_vld && is_empty;
    assign head_dat  = is_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module vchanel_fifo_bank #(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2,
    parameter int AF_THRESH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              push,
    input  logic [1:0]        class_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        pop_vchanel,
    output logic [DATA_W-1:0] out_vchanel0,
    output logic [DATA_W-1:0] out_vchanel1,
    output logic [DATA_W-1:0] out_vchanel2,
    output logic [DATA_W-1:0] out_vchanel3,
    output logic              empty_vchanel0,
    output logic              empty_vchanel1,
    output logic              empty_vchanel2,
    output logic              empty_vchanel3,
    output logic [3:0]        almost_full_vchanel,
    output logic [3:0]        full_vchanel,
    output logic              overflow_err,
    output logic              underflow_err
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AF_CNT   = (PTR_W+1)'(AF_THRESH);

    logic [DATA_W-1:0] head [4];
    logic [PTR_W:0]    cnt  [4];
    logic [3:0]        empty;
    logic [3:0]        drop;
    logic [3:0]        udf;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_vc
            vc_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .PTR_W  (PTR_W)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push_vld  (enb && push && (class_in == 2'(g))),
                .push_dat  (data_in),
                .pop_vld   (enb && pop_vchanel[g]),
                .head_dat  (head[g]),
                .count     (cnt[g]),
                .push_drop (drop[g]),
                .pop_udf   (udf[g])
            );
            assign empty[g]               = (cnt[g] == '0);
            assign full_vchanel[g]        = (cnt[g] == FULL_CNT);
            assign almost_full_vchanel[g] = (cnt[g] >= AF_CNT);
        end
    endgenerate

    assign out_vchanel0   = head[0];
    assign out_vchanel1   = head[1];
    assign out_vchanel2   = head[2];
    assign out_vchanel3   = head[3];
    assign empty_vchanel0 = empty[0];
    assign empty_vchanel1 = empty[1];
    assign empty_vchanel2 = empty[2];
    assign empty_vchanel3 = empty[3];

    // Sticky until reset; enb is already folded into drop/udf.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (|drop) begin
                overflow_err <= 1'b1;
            end
            if (|udf) begin
                underflow_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vchanel_fifo_bank.sv
// Directed bench for vchanel_fifo_bank with hand-computed expectations per scenario.
module tb_vchanel_fifo_bank;
    logic       clk;
    logic       rst;
    logic       enb;
    logic       push;
    logic [1:0] class_in;
    logic [3:0] data_in;
    logic [3:0] pop_vchanel;
    logic [3:0] out0, out1, out2, out3;
    logic       e0, e1, e2, e3;
    logic [3:0] af;
    logic [3:0] full;
    logic       ovf;
    logic       udf;

    int checks = 0;
    int errors = 0;

    vchanel_fifo_bank dut (
        .clk                 (clk),
        .rst                 (rst),
        .enb                 (enb),
        .push                (push),
        .class_in            (class_in),
        .data_in             (data_in),
        .pop_vchanel         (pop_vchanel),
        .out_vchanel0        (out0),
        .out_vchanel1        (out1),
        .out_vchanel2        (out2),
        .out_vchanel3        (out3),
        .empty_vchanel0      (e0),
        .empty_vchanel1      (e1),
        .empty_vchanel2      (e2),
        .empty_vchanel3      (e3),
        .almost_full_vchanel (af),
        .full_vchanel        (full),
        .overflow_err        (ovf),
        .underflow_err       (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enb = 1'b1; push = 1'b0; class_in = 2'd0; data_in = 4'h0; pop_vchanel = 4'b0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic push_word(input logic [1:0] c, input logic [3:0] d);
        push = 1'b1; class_in = c; data_in = d;
        step();
        push = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++; if ({e3, e2, e1, e0} !== 4'b1111) begin errors++; $display("FAIL reset_empty: got %b expected 1111", {e3, e2, e1, e0}); end
            checks++; if ({out3, out2, out1, out0} !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", {out3, out2, out1, out0}); end
            checks++; if (af !== 4'b0000) begin errors++; $display("FAIL reset_af: got %b expected 0000", af); end
            checks++; if (full !== 4'b0000) begin errors++; $display("FAIL reset_full: got %b expected 0000", full); end
            checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {ovf, udf}); end
            step();
        end
    endtask

    task automatic test_single_push_pop();
        push_word(2'd2, 4'hA);
        checks++; if (e2 !== 1'b0) begin errors++; $display("FAIL single_empty2: got %b expected 0", e2); end
        checks++; if (out2 !== 4'hA) begin errors++; $display("FAIL single_out2: got %h expected a", out2); end
        checks++; if ({e3, e1, e0} !== 3'b111) begin errors++; $display("FAIL single_others: got %b expected 111", {e3, e1, e0}); end
        pop_vchanel = 4'b0100;
        step();
        pop_vchanel = 4'b0000;
        checks++; if (e2 !== 1'b1) begin errors++; $display("FAIL single_pop_empty2: got %b expected 1", e2); end
        checks++; if (out2 !== 4'h0) begin errors++; $display("FAIL single_pop_out2: got %h expected 0", out2); end
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL single_udf: got %b expected 0", udf); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            push_word(2'd1, 4'(i));
            checks++; if (af[1] !== (i >= 3)) begin errors++; $display("FAIL fill_af push%0d: got %b expected %b", i, af[1], (i >= 3)); end
            checks++; if (full[1] !== (i == 4)) begin errors++; $display("FAIL fill_full push%0d: got %b expected %b", i, full[1], (i == 4)); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf_before: got %b expected 0", ovf); end
        push_word(2'd1, 4'h5);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b expected 1", ovf); end
        checks++; if (full[1] !== 1'b1) begin errors++; $display("FAIL fill_still_full: got %b expected 1", full[1]); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out1 !== 4'(i)) begin errors++; $display("FAIL fill_order pop%0d: got %h expected %h", i, out1, 4'(i)); end
            pop_vchanel = 4'b0010;
            step();
            pop_vchanel = 4'b0000;
        end
        checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL fill_drained: got %b expected 1", e1); end
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL fill_udf: got %b expected 0", udf); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) push_word(2'd0, 4'(i));
        pop_vchanel = 4'b0001;
        push_word(2'd0, 4'h7);
        pop_vchanel = 4'b0000;
        checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", full[0]); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", ovf); end
        for (int i = 2; i <= 4; i++) begin
            checks++; if (out0 !== 4'(i)) begin errors++; $display("FAIL fpp_head%0d: got %h expected %h", i, out0, 4'(i)); end
            pop_vchanel = 4'b0001;
            step();
            pop_vchanel = 4'b0000;
        end
        checks++; if (out0 !== 4'h7) begin errors++; $display("FAIL fpp_last: got %h expected 7", out0); end
    endtask

    task automatic test_underflow_push();
        do_reset();
        pop_vchanel = 4'b1000;
        push_word(2'd3, 4'h9);
        pop_vchanel = 4'b0000;
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL uf_udf: got %b expected 1", udf); end
        checks++; if (e3 !== 1'b0) begin errors++; $display("FAIL uf_empty3: got %b expected 0", e3); end
        checks++; if (out3 !== 4'h9) begin errors++; $display("FAIL uf_out3: got %h expected 9", out3); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL uf_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_wrap_enable();
        do_reset();
        push_word(2'd0, 4'h1);
        push_word(2'd0, 4'h2);
        push_word(2'd0, 4'h3);
        pop_vchanel = 4'b0001;
        push_word(2'd0, 4'h4);
        pop_vchanel = 4'b0000;
        enb = 1'b0; push = 1'b1; class_in = 2'd0; data_in = 4'hF; pop_vchanel = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (out0 !== 4'h2) begin errors++; $display("FAIL wrap_hold_out cyc%0d: got %h expected 2", i, out0); end
            checks++; if ({full[0], af[0], e0} !== 3'b010) begin errors++; $display("FAIL wrap_hold_flags cyc%0d: got %b expected 010", i, {full[0], af[0], e0}); end
            checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL wrap_hold_err cyc%0d: got %b expected 00", i, {ovf, udf}); end
        end
        idle_inputs();
        pop_vchanel = 4'b0001;
        push_word(2'd0, 4'h5);
        pop_vchanel = 4'b0000;
        push_word(2'd0, 4'h6);
        checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL wrap_full: got %b expected 1", full[0]); end
        for (int i = 3; i <= 6; i++) begin
            checks++; if (out0 !== 4'(i)) begin errors++; $display("FAIL wrap_order%0d: got %h expected %h", i, out0, 4'(i)); end
            pop_vchanel = 4'b0001;
            step();
            pop_vchanel = 4'b0000;
        end
        checks++; if (e0 !== 1'b1) begin errors++; $display("FAIL wrap_drained: got %b expected 1", e0); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_word(2'd0, 4'hB);
        push_word(2'd1, 4'hC);
        pop_vchanel = 4'b0100;
        step();
        pop_vchanel = 4'b0000;
        checks++; if ({udf, e1, e0} !== 3'b100) begin errors++; $display("FAIL ar_pre: got %b expected 100", {udf, e1, e0}); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({e3, e2, e1, e0} !== 4'b1111) begin errors++; $display("FAIL ar_empty: got %b expected 1111", {e3, e2, e1, e0}); end
        checks++; if ({out1, out0} !== 8'h00) begin errors++; $display("FAIL ar_out: got %h expected 00", {out1, out0}); end
        checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL ar_err: got %b expected 00", {ovf, udf}); end
        #1;
        rst = 1'b1;
        push_word(2'd0, 4'h3);
        checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL ar_post_empty: got %b expected 0", e0); end
        checks++; if (out0 !== 4'h3) begin errors++; $display("FAIL ar_post_out: got %h expected 3", out0); end
    endtask

    initial begin
        test_reset();
        test_single_push_pop();
        test_fill_overflow();
        test_full_push_pop();
        test_underflow_push();
        test_wrap_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
